dco_nco_bank: RTL
=================

// Module: dco_nco_bank
// PURPOSE
//  Parametrised successor to the single-channel 8-bit DCO: N_CH independent
//  phase-accumulator oscillators. Each channel's frequency is set by a tuning code written through one shared
//  port. The code is double-buffered and takes effect only at a phase wrap, so frequency changes are glitch-free.
//  Four output modes (square / wrap-pulse / divide-by-2 / off). Sits behind the tt_um top: ui_in carries the code,
//  uo_out carries the channel outputs.
// PARAMETERS
//  CODE_W  8   tuning-code width; increment = zero-extended code
//  ACC_W   16  phase accumulator width (>= CODE_W); f_out = f_clk*code/2^ACC_W
//  N_CH    2   number of channels (1..8)
//  SEL_W   $clog2(N_CH) (min 1)  channel-select width (localparam)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       reset, synchronous, active-low
//  ena        in   1       global enable; low = all state frozen
//  code_in    in   CODE_W  tuning code to write
//  ch_sel     in   SEL_W   target channel for code_wr
//  code_wr    in   1       write strobe, 1-cycle, qualified by ena
//  mode       in   2       00 square, 01 wrap pulse, 10 toggle-on-wrap, 11 off
//  dco_out    out  N_CH    registered oscillator outputs
//  wrap       out  N_CH    registered 1-cycle phase-wrap flags (valid in every mode)
//  pend       out  N_CH    1 = written code not yet applied to the channel
// BEHAVIOUR
//  - Sync reset (rst_n=0 at edge): acc, active_inc, pending_inc, toggle=0. dco_out, wrap, pend=0. Reset overrides
//    everything, including mid-write and mid-period.
//  - ena=0: no register changes (outputs hold their last values). A code_wr strobe while ena=0 is ignored.
//  - Write: code_wr&ena at edge E: pending_inc[ch_sel]<=code_in, pend[ch_sel]<=1. An out-of-range ch_sel
//    (>=N_CH) is ignored.
//  - Per channel, each enabled edge: {carry,acc_nxt}=acc+active_inc (ACC_W+1 bits); acc<=acc_nxt (mod 2^ACC_W wrap).
//  - Apply: if carry==1 OR active_inc==0, then active_inc<=pending_inc and pend<=0.
//    A stopped channel (inc 0) loads on the first edge after a write. A running channel loads only at the wrap edge.
//  - Write on the same edge as a wrap of that channel: the wrap applies the OLD pending_inc. The new code is captured
//    into pending_inc and pend stays 1 until the next wrap.
//  - Code 0 applied: acc freezes at its current value; carry=0 thereafter. dco_out holds in square and toggle modes,
//    and is 0 in pulse mode.
//  - Outputs, registered at the same edge as acc: wrap<=carry; toggle<=toggle^carry;
//    square: dco_out<=acc_nxt[ACC_W-1]; pulse: dco_out<=carry; toggle: dco_out<=toggle^carry; off: dco_out<=0.
//  - mode is global and takes effect at the next edge. acc/toggle keep running in every mode, so a mode
//    switch does not reset phase.
//  - Latency for a stopped channel: write at E0 -> active_inc at E1 -> first acc step at E2.
// STRUCTURE
//  - Package dco_pkg: mode localparams (MODE_SQ=2'b00, MODE_PULSE=2'b01, MODE_TOG=2'b10, MODE_OFF=2'b11).
//  - Sub-module nco_channel (one per channel, generate loop): holds acc, active_inc, pending_inc, toggle,
//    pend and the output regs. Inputs: wr_en, code, mode, ena.
//  - Top: ch_sel decode into per-channel wr_en, plus generate loop. No other logic.
// TESTING (bench ACC_W=8, CODE_W=8, N_CH=2 unless stated)
//  1 Reset: hold rst_n=0 for 3 clocks with random code_wr -> dco_out=wrap=pend=0. Release: outputs stay 0
//    (codes 0).
//  2 Write ch0=0x40, mode square -> pend[0] high for 1 cycle; dco_out[0] period 4 clk, 2 high/2 low;
//    wrap[0] every 4 clk; ch1 stays 0.
//  3 Running ch0=0x40; write 0x80 mid-period -> pend[0]=1 until the next wrap. Old period is completed
//    exactly, then period is 2 clk. No short or long pulse at the switch.
//  4 Write collides with wrap edge (ch0 0x40->0x20) -> the colliding wrap keeps 0x40 (next wrap in 4 clk);
//    0x20 takes effect from the following wrap (period 8).
//  5 Modes, ch1=0x20: pulse -> 1-clk high every 8 clk; toggle -> 50% duty, period 16; off -> constant 0,
//    while wrap[1] still pulses every 8.
//  6 ena=0 for 5 clk mid-period, with code_wr asserted -> all outputs frozen, write ignored (pend stays 0).
//    Phase resumes exactly on ena=1.

Source files
------------

// File: rtl/dco_pkg.sv
// Shared constants for the NCO bank: output-mode encodings.
package dco_pkg;
    localparam logic [1:0] MODE_SQ    = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_TOG   = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;
endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator oscillator with a double-buffered tuning code that
// is only applied at a phase wrap (or immediately when the channel is stopped).
module nco_channel
    import dco_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] code,
    input  logic [1:0]        mode,
    output logic              dco_out,
    output logic              wrap,
    output logic              pend
);
    logic [ACC_W-1:0]  acc_reg;
    logic [CODE_W-1:0] active_inc_reg;
    logic [CODE_W-1:0] pending_inc_reg;
    logic              toggle_reg;
    logic              dco_out_reg;
    logic              wrap_reg;
    logic              pend_reg;

    logic [ACC_W:0]    sum;
    logic              carry;
    logic [ACC_W-1:0]  acc_next;
    logic              toggle_next;
    logic              dco_next;
    logic              apply;

    always_comb begin
        sum         = {1'b0, acc_reg} + (ACC_W+1)'(active_inc_reg);
        carry       = sum[ACC_W];
        acc_next    = sum[ACC_W-1:0];
        toggle_next = toggle_reg ^ carry;
        // A stopped channel has no wrap to wait for, so it loads at once.
        apply       = carry || (active_inc_reg == '0);
        dco_next    = 1'b0;
        case (mode)
            MODE_SQ:    dco_next = acc_next[ACC_W-1];
            MODE_PULSE: dco_next = carry;
            MODE_TOG:   dco_next = toggle_next;
            default:    dco_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg         <= '0;
            active_inc_reg  <= '0;
            pending_inc_reg <= '0;
            toggle_reg      <= 1'b0;
            dco_out_reg     <= 1'b0;
            wrap_reg        <= 1'b0;
            pend_reg        <= 1'b0;
        end else if (ena) begin
            acc_reg     <= acc_next;
            toggle_reg  <= toggle_next;
            wrap_reg    <= carry;
            dco_out_reg <= dco_next;
            if (apply) begin
                active_inc_reg <= pending_inc_reg;
                pend_reg       <= 1'b0;
            end
            // A write colliding with a wrap lands after the old code was applied.
            if (wr_en) begin
                pending_inc_reg <= code;
                pend_reg        <= 1'b1;
            end
        end
    end

    assign dco_out = dco_out_reg;
    assign wrap    = wrap_reg;
    assign pend    = pend_reg;
endmodule

// File: rtl/dco_nco_bank.sv
// Bank of N_CH independent NCO channels sharing one code-write port and a
// global output mode.
module dco_nco_bank
    import dco_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int ACC_W  = 16,
    parameter int N_CH   = 2,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CODE_W-1:0] code_in,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic              code_wr,
    input  logic [1:0]        mode,
    output logic [N_CH-1:0]   dco_out,
    output logic [N_CH-1:0]   wrap,
    output logic [N_CH-1:0]   pend
);
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            // Out-of-range selects match no channel and are dropped.
            nco_channel #(
                .CODE_W (CODE_W),
                .ACC_W  (ACC_W)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .ena     (ena),
                .wr_en   (code_wr && (ch_sel == SEL_W'(gi))),
                .code    (code_in),
                .mode    (mode),
                .dco_out (dco_out[gi]),
                .wrap    (wrap[gi]),
                .pend    (pend[gi])
            );
        end
    endgenerate
endmodule
